// File: rtl/dm_port_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and a DMA/loader master.
// Latency: CPU access is combinational (0 cycles); DMA read data returns 1 cycle after grant.
// Backpressure: CPU sees cpu_stall when not owner; DMA sees dma_gnt only when it owns the port.
module dm_port_arbiter #(
    parameter int MAX_WAIT  = 8,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_flush,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [3:0]  dma_be,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wd,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,

    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    input  logic [31:0] dm_rd
);

    // Counter widths; a limit of 1 still needs a 1-bit register.
    localparam int WW = (MAX_WAIT  > 1) ? $clog2(MAX_WAIT)  : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    state_t          state;
    owner_t          owner;
    logic [WW-1:0]   wait_cnt;
    logic [BW-1:0]   burst_cnt;

    // Pick this cycle's port owner: CPU first in S_CPU, DMA exclusively in S_DMA.
    always_comb begin
        owner = OWN_NONE;
        if (state == S_DMA) begin
            if (dma_req) begin
                owner = OWN_DMA;
            end
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end else if (dma_req) begin
            owner = OWN_DMA;
        end
    end

    // Drive the memory port from the owner; an idle port is fully zeroed so
    // nothing stale reaches dm, and writes are blocked while in reset.
    always_comb begin
        dm_we   = 1'b0;
        dm_be   = 4'b0000;
        dm_addr = 32'h0;
        dm_wd   = 32'h0;
        case (owner)
            OWN_CPU: begin
                dm_we   = cpu_we & ~cpu_flush;
                dm_be   = cpu_be;
                dm_addr = cpu_addr;
                dm_wd   = cpu_wd;
            end
            OWN_DMA: begin
                dm_we   = dma_we;
                dm_be   = dma_be;
                dm_addr = dma_addr;
                dm_wd   = dma_wd;
            end
            default: begin
            end
        endcase
        if (!reset) begin
            dm_we = 1'b0;
        end
    end

    // Handshakes are suppressed during reset so neither master believes it was served.
    always_comb begin
        dma_gnt   = reset & (owner == OWN_DMA);
        cpu_stall = reset & cpu_req & (owner != OWN_CPU);
    end

    // CPU reads are async straight from the memory.
    assign cpu_rd = dm_rd;

    // Arbitration FSM with starvation counter, burst counter and DMA read-return register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_CPU;
            wait_cnt   <= '0;
            burst_cnt  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= 32'h0;
        end else begin
            dma_rvalid <= dma_gnt & ~dma_we;
            if (dma_gnt && !dma_we) begin
                dma_rdata <= dm_rd;
            end

            case (state)
                S_CPU: begin
                    if (dma_req && !dma_gnt) begin
                        // DMA is being starved by the CPU; force a burst once the limit is hit.
                        if (wait_cnt == WAIT_LAST) begin
                            state     <= S_DMA;
                            wait_cnt  <= '0;
                            burst_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        // Either DMA got an opportunistic beat or it is not asking.
                        wait_cnt <= '0;
                    end
                end
                S_DMA: begin
                    if (dma_gnt) begin
                        if (burst_cnt == BURST_LAST) begin
                            state     <= S_CPU;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else begin
                        // DMA dropped its request mid-burst: hand the port back.
                        state     <= S_CPU;
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    state     <= S_CPU;
                    wait_cnt  <= '0;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    // The port is never handed to both masters in one cycle.
    a_exclusive_owner: assert property (@(posedge clk) disable iff (!reset)
        !(dma_gnt && cpu_req && !cpu_stall));

    // A DMA write never produces read-return data.
    a_no_rvalid_on_write: assert property (@(posedge clk) disable iff (!reset)
        (dma_gnt && dma_we) |=> !dma_rvalid);

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_flush;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr, cpu_wd, cpu_rd;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [3:0]  dma_be;
    logic [31:0] dma_addr, dma_wd;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wd, dm_rd;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    dm_port_arbiter #(.MAX_WAIT(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_flush(cpu_flush), .cpu_be(cpu_be),
        .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr),
        .dma_wd(dma_wd), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_rd(dm_rd)
    );

    // Data memory model: async read, byte-enabled synchronous write.
    assign dm_rd = mem[dm_addr[9:2]];
    always @(posedge clk) begin
        if (dm_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dm_be[b]) mem[dm_addr[9:2]][8*b +: 8] <= dm_wd[8*b +: 8];
            end
        end
    end

    // Scoreboard for DMA read return, sampled away from the active edge.
    always @(negedge clk) begin
        if (dma_rvalid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rvalid_unexpected: got rdata %h, no read outstanding", dma_rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (dma_rdata !== e) begin
                    fails++;
                    $display("FAIL rdata_scoreboard: got %h want %h", dma_rdata, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_flush = 0; cpu_be = 4'h0; cpu_addr = 0; cpu_wd = 0;
        dma_req = 0; dma_we = 0; dma_be = 4'h0; dma_addr = 0; dma_wd = 0;
    endtask

    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
        idle();
        cpu_req = 1; cpu_we = 1; cpu_be = 4'hF; cpu_addr = a; cpu_wd = d;
        step();
        idle();
    endtask

    task automatic test_reset();
        reset = 0;
        cpu_req = 1; cpu_we = 1; cpu_be = 4'hF; cpu_addr = 32'h40;
        dma_req = 1; dma_we = 1; dma_be = 4'hF; dma_addr = 32'h80;
        step(); step();
        #1;
        tests++; if (dm_we !== 1'b0) begin fails++; $display("FAIL rst_dm_we: got %b want 0", dm_we); end
        tests++; if (dma_gnt !== 1'b0) begin fails++; $display("FAIL rst_dma_gnt: got %b want 0", dma_gnt); end
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL rst_cpu_stall: got %b want 0", cpu_stall); end
        tests++; if (dma_rvalid !== 1'b0) begin fails++; $display("FAIL rst_rvalid: got %b want 0", dma_rvalid); end
        tests++; if (dma_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0", dma_rdata); end
        step();
        reset = 1;
        idle();
        step();
        // Out of reset in S_CPU: CPU wins a contended cycle.
        cpu_req = 1; dma_req = 1;
        #1;
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL rst_state_cpu: got stall %b want 0", cpu_stall); end
        idle();
        step();
    endtask

    task automatic test_idle_port();
        idle();
        #1;
        tests++; if (dm_addr !== 32'h0) begin fails++; $display("FAIL idle_addr: got %h want 0", dm_addr); end
        tests++; if (dm_be !== 4'h0) begin fails++; $display("FAIL idle_be: got %h want 0", dm_be); end
        tests++; if (dm_wd !== 32'h0) begin fails++; $display("FAIL idle_wd: got %h want 0", dm_wd); end
        step();
    endtask

    task automatic test_cpu_write();
        idle();
        cpu_req = 1; cpu_we = 1; cpu_be = 4'hF; cpu_addr = 32'h0000_1004; cpu_wd = 32'h1234_5678;
        #1;
        tests++; if (dm_we !== 1'b1) begin fails++; $display("FAIL cpuw_dm_we: got %b want 1", dm_we); end
        tests++; if (dm_addr !== 32'h1004) begin fails++; $display("FAIL cpuw_addr: got %h want 1004", dm_addr); end
        tests++; if (dm_wd !== 32'h1234_5678) begin fails++; $display("FAIL cpuw_wd: got %h want 12345678", dm_wd); end
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL cpuw_stall: got %b want 0", cpu_stall); end
        step();
        cpu_we = 0;
        #1;
        tests++; if (cpu_rd !== 32'h1234_5678) begin fails++; $display("FAIL cpuw_readback: got %h want 12345678", cpu_rd); end
        idle();
        step();
    endtask

    task automatic test_dma_read();
        cpu_store(32'h100, 32'hCAFE_0001);
        dma_req = 1; dma_we = 0; dma_be = 4'hF; dma_addr = 32'h100;
        #1;
        tests++; if (dma_gnt !== 1'b1) begin fails++; $display("FAIL dmar_gnt: got %b want 1", dma_gnt); end
        tests++; if (dm_addr !== 32'h100) begin fails++; $display("FAIL dmar_addr: got %h want 100", dm_addr); end
        tests++; if (dm_we !== 1'b0) begin fails++; $display("FAIL dmar_we: got %b want 0", dm_we); end
        exp_q.push_back(32'hCAFE_0001);
        step();
        idle();
        tests++; if (dma_rvalid !== 1'b1) begin fails++; $display("FAIL dmar_rvalid: got %b want 1", dma_rvalid); end
        tests++; if (dma_rdata !== 32'hCAFE_0001) begin fails++; $display("FAIL dmar_rdata: got %h want cafe0001", dma_rdata); end
        step();
        // Still S_CPU: CPU takes a contended cycle.
        cpu_req = 1; cpu_addr = 32'h200; dma_req = 1; dma_addr = 32'h100;
        #1;
        tests++; if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin
            fails++; $display("FAIL dmar_state: got stall %b gnt %b want 0 0", cpu_stall, dma_gnt); end
        step();
        idle();
        step();
    endtask

    task automatic test_starvation();
        logic g;
        idle();
        cpu_req = 1; cpu_addr = 32'h200; dma_req = 1; dma_we = 0; dma_be = 4'hF; dma_addr = 32'h100;
        for (int c = 0; c < 13; c++) begin
            #1;
            g = (c >= 8 && c <= 11);
            tests++; if (dma_gnt !== g) begin fails++; $display("FAIL starve_gnt c%0d: got %b want %b", c, dma_gnt, g); end
            tests++; if (cpu_stall !== g) begin fails++; $display("FAIL starve_stall c%0d: got %b want %b", c, cpu_stall, g); end
            if (g) exp_q.push_back(32'hCAFE_0001);
            step();
        end
        idle();
        step();
    endtask

    task automatic test_burst_early_exit();
        logic g, s;
        idle();
        cpu_req = 1; cpu_addr = 32'h200; dma_we = 0; dma_be = 4'hF; dma_addr = 32'h100;
        for (int c = 0; c < 24; c++) begin
            dma_req = (c != 10);
            #1;
            g = (c == 8 || c == 9 || (c >= 19 && c <= 22));
            s = g || (c == 10);
            tests++; if (dma_gnt !== g) begin fails++; $display("FAIL early_gnt c%0d: got %b want %b", c, dma_gnt, g); end
            tests++; if (cpu_stall !== s) begin fails++; $display("FAIL early_stall c%0d: got %b want %b", c, cpu_stall, s); end
            if (g) exp_q.push_back(32'hCAFE_0001);
            step();
        end
        idle();
        step();
    endtask

    task automatic test_reset_midburst();
        logic g;
        idle();
        cpu_req = 1; cpu_addr = 32'h200; dma_req = 1; dma_we = 0; dma_be = 4'hF; dma_addr = 32'h100;
        for (int c = 0; c < 9; c++) begin
            #1;
            g = (c == 8);
            tests++; if (dma_gnt !== g) begin fails++; $display("FAIL mrst_pre_gnt c%0d: got %b want %b", c, dma_gnt, g); end
            if (g) exp_q.push_back(32'hCAFE_0001);
            step();
        end
        reset = 0;
        #1;
        tests++; if (dma_gnt !== 1'b0) begin fails++; $display("FAIL mrst_gnt: got %b want 0", dma_gnt); end
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL mrst_stall: got %b want 0", cpu_stall); end
        step();
        reset = 1;
        tests++; if (dma_rvalid !== 1'b0) begin fails++; $display("FAIL mrst_rvalid: got %b want 0", dma_rvalid); end
        tests++; if (dma_rdata !== 32'h0) begin fails++; $display("FAIL mrst_rdata: got %h want 0", dma_rdata); end
        // Counters cleared: full wait window and full burst again.
        for (int r = 0; r < 13; r++) begin
            #1;
            g = (r >= 8 && r <= 11);
            tests++; if (dma_gnt !== g) begin fails++; $display("FAIL mrst_post_gnt r%0d: got %b want %b", r, dma_gnt, g); end
            tests++; if (cpu_stall !== g) begin fails++; $display("FAIL mrst_post_stall r%0d: got %b want %b", r, cpu_stall, g); end
            if (g) exp_q.push_back(32'hCAFE_0001);
            step();
        end
        idle();
        step();
    endtask

    task automatic test_flush();
        cpu_store(32'h300, 32'hA5A5_A5A5);
        cpu_req = 1; cpu_we = 1; cpu_flush = 1; cpu_be = 4'hF; cpu_addr = 32'h300; cpu_wd = 32'hDEAD_BEEF;
        #1;
        tests++; if (dm_we !== 1'b0) begin fails++; $display("FAIL flush_we: got %b want 0", dm_we); end
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b want 0", cpu_stall); end
        step();
        cpu_we = 0; cpu_flush = 0;
        #1;
        tests++; if (cpu_rd !== 32'hA5A5_A5A5) begin fails++; $display("FAIL flush_mem: got %h want a5a5a5a5", cpu_rd); end
        idle();
        step();
    endtask

    task automatic test_dma_write();
        idle();
        dma_req = 1; dma_we = 1; dma_be = 4'b0011; dma_addr = 32'h300; dma_wd = 32'h1111_2222;
        #1;
        tests++; if (dma_gnt !== 1'b1) begin fails++; $display("FAIL dmaw_gnt: got %b want 1", dma_gnt); end
        tests++; if (dm_we !== 1'b1) begin fails++; $display("FAIL dmaw_we: got %b want 1", dm_we); end
        tests++; if (dm_be !== 4'b0011) begin fails++; $display("FAIL dmaw_be: got %b want 0011", dm_be); end
        step();
        idle();
        tests++; if (dma_rvalid !== 1'b0) begin fails++; $display("FAIL dmaw_rvalid: got %b want 0", dma_rvalid); end
        cpu_req = 1; cpu_addr = 32'h300;
        #1;
        tests++; if (cpu_rd !== 32'hA5A5_2222) begin fails++; $display("FAIL dmaw_mem: got %h want a5a52222", cpu_rd); end
        idle();
        step();
    endtask

    initial begin
        idle();
        reset = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_idle_port();
        test_cpu_write();
        test_dma_read();
        test_starvation();
        test_burst_early_exit();
        test_reset_midburst();
        test_flush();
        test_dma_write();
        step(); step(); step();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d reads outstanding want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
